// File: rtl/emergency_request_arbiter.sv
// Purpose: debounces the two emergency sensors and grants one side at a time to the light controller.
// Latency: a clean request first sampled at edge k raises em_* after edge k+DEBOUNCE; all outputs are registered.
// Backpressure: none; requests stay pending in the debounced levels while a grant or cooldown is in progress.
module emergency_request_arbiter #(
    parameter int CW         = 8,
    parameter int DEBOUNCE   = 3,
    parameter int HOLD       = 10,
    parameter int MAX_GRANT  = 40,
    parameter int COOLDOWN   = 5,
    parameter int STARVE_MAX = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic req_left,
    input  logic req_right,
    output logic em_left,
    output logic em_right,
    output logic busy,
    output logic forced_release,
    output logic starve_flag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_R = 2'd1,
        GRANT_L = 2'd2,
        COOL    = 2'd3
    } state_t;

    // Terminal counts, pre-sized to the counter width so comparisons stay width-clean.
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
    localparam logic [CW-1:0] MAXG_LAST  = CW'(MAX_GRANT - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN - 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    state_t        state;
    state_t        state_nxt;
    logic          force_nxt;
    logic          db_l;
    logic          db_r;
    logic [CW-1:0] db_cnt_l;
    logic [CW-1:0] db_cnt_r;
    logic [CW-1:0] grant_cnt;
    logic [CW-1:0] cool_cnt;
    logic [CW-1:0] left_wait;
    logic [CW-1:0] left_wait_nxt;

    // Left debounce: db_l follows the raw level only after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_l     <= 1'b0;
            db_cnt_l <= '0;
        end else if (req_left != db_l) begin
            if (db_cnt_l == DB_LAST) begin
                db_l     <= req_left;
                db_cnt_l <= '0;
            end else begin
                db_cnt_l <= db_cnt_l + 1'b1;
            end
        end else begin
            db_cnt_l <= '0;
        end
    end

    // Right debounce: identical filter for the right sensor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_r     <= 1'b0;
            db_cnt_r <= '0;
        end else if (req_right != db_r) begin
            if (db_cnt_r == DB_LAST) begin
                db_r     <= req_right;
                db_cnt_r <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + 1'b1;
            end
        end else begin
            db_cnt_r <= '0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: starving left beats right, right beats left, and the grant limit beats a held request.
    always_comb begin
        state_nxt = state;
        force_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (db_l && (left_wait >= STARVE_LIM)) begin
                    state_nxt = GRANT_L;
                end else if (db_r) begin
                    state_nxt = GRANT_R;
                end else if (db_l) begin
                    state_nxt = GRANT_L;
                end
            end
            GRANT_R: begin
                if (grant_cnt == MAXG_LAST) begin
                    state_nxt = COOL;
                    force_nxt = 1'b1;
                end else if ((grant_cnt >= HOLD_LAST) && !db_r) begin
                    state_nxt = COOL;
                end
            end
            GRANT_L: begin
                if (grant_cnt == MAXG_LAST) begin
                    state_nxt = COOL;
                    force_nxt = 1'b1;
                end else if ((grant_cnt >= HOLD_LAST) && !db_l) begin
                    state_nxt = COOL;
                end
            end
            COOL: begin
                if (cool_cnt == COOL_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant and cooldown length counters; any state change clears both so each starts from zero on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt <= '0;
            cool_cnt  <= '0;
        end else if (state_nxt != state) begin
            grant_cnt <= '0;
            cool_cnt  <= '0;
        end else begin
            if ((state == GRANT_R) || (state == GRANT_L)) begin
                grant_cnt <= grant_cnt + 1'b1;
            end
            if (state == COOL) begin
                cool_cnt <= cool_cnt + 1'b1;
            end
        end
    end

    // How long a debounced left request has gone unserved; saturates instead of wrapping.
    always_comb begin
        left_wait_nxt = left_wait;
        if (!db_l) begin
            left_wait_nxt = '0;
        end else if ((state_nxt == GRANT_L) && (state != GRANT_L)) begin
            left_wait_nxt = '0;
        end else if ((state != GRANT_L) && (left_wait != '1)) begin
            left_wait_nxt = left_wait + 1'b1;
        end
    end

    // Left wait register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_wait <= '0;
        end else begin
            left_wait <= left_wait_nxt;
        end
    end

    // Outputs registered from next-state values so they change exactly with the state and never see req_* directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            em_left        <= 1'b0;
            em_right       <= 1'b0;
            busy           <= 1'b0;
            forced_release <= 1'b0;
            starve_flag    <= 1'b0;
        end else begin
            em_left        <= (state_nxt == GRANT_L);
            em_right       <= (state_nxt == GRANT_R);
            busy           <= (state_nxt != IDLE);
            forced_release <= force_nxt;
            starve_flag    <= (left_wait_nxt >= STARVE_LIM);
        end
    end

endmodule

// File: tb/tb_emergency_request_arbiter.sv
// Purpose: directed self-checking bench for emergency_request_arbiter.
// Latency: checks sample 1 time unit after each rising edge; every run is a fixed number of cycles.
// Backpressure: not applicable; stimulus is driven open-loop.
module tb_emergency_request_arbiter;

    logic clk;
    logic reset;
    logic req_left;
    logic req_right;
    logic em_left;
    logic em_right;
    logic busy;
    logic forced_release;
    logic starve_flag;

    int n_vec;
    int n_bad;
    int c_l;
    int c_r;
    int c_busy;
    int c_fr;
    int c_both;
    int c_st;

    emergency_request_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req_left       (req_left),
        .req_right      (req_right),
        .em_left        (em_left),
        .em_right       (em_right),
        .busy           (busy),
        .forced_release (forced_release),
        .starve_flag    (starve_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        c_l = 0; c_r = 0; c_busy = 0; c_fr = 0; c_both = 0; c_st = 0;
    endtask

    task automatic sample();
        c_l    += int'(em_left);
        c_r    += int'(em_right);
        c_busy += int'(busy);
        c_fr   += int'(forced_release);
        c_both += int'(em_left & em_right);
        c_st   += int'(starve_flag);
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            sample();
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        clr();
        reset     = 1'b1;
        req_left  = 1'b0;
        req_right = 1'b0;

        // Reset state, before and after a clock edge.
        #1;
        check_val("rst_outs", {em_left, em_right, busy, forced_release, starve_flag}, 0);
        cyc();
        check_val("rst_outs_edge", {em_left, em_right, busy, forced_release, starve_flag}, 0);
        #2 reset = 1'b0;
        run_count(3);

        // T1: two-cycle glitch must be filtered out.
        clr();
        req_right = 1'b1;
        run_count(2);
        req_right = 1'b0;
        run_count(10);
        check_val("t1_em_right", c_r, 0);
        check_val("t1_busy", c_busy, 0);

        // T2: three-cycle right request gives a HOLD-length grant and a COOL tail.
        req_right = 1'b1;
        run_count(3);
        check_val("t2_pre_grant", int'(em_right), 0);
        req_right = 1'b0;
        cyc();
        check_val("t2_latency", int'(em_right), 1);
        clr();
        sample();
        run_count(24);
        check_val("t2_grant_len", c_r, 10);
        check_val("t2_busy_len", c_busy, 15);
        check_val("t2_forced", c_fr, 0);
        check_val("t2_idle", int'(busy), 0);

        // T3: held left request is cut at MAX_GRANT, cools, then re-granted from IDLE.
        req_left = 1'b1;
        clr();
        run_count(3);
        check_val("t3_pre_grant", c_l, 0);
        cyc();
        check_val("t3_latency", int'(em_left), 1);
        clr();
        sample();
        run_count(45);
        check_val("t3_grant_len", c_l, 40);
        check_val("t3_busy_len", c_busy, 45);
        check_val("t3_forced_once", c_fr, 1);
        check_val("t3_idle_gap", int'(em_left), 0);
        cyc();
        check_val("t3_regrant", int'(em_left), 1);
        req_left = 1'b0;
        run_count(30);
        check_val("t3_settle", int'(busy), 0);

        // T4: simultaneous requests: right twice, starvation flag rises, then left.
        req_left  = 1'b1;
        req_right = 1'b1;
        run_count(3);
        cyc();
        check_val("t4_first_right", int'(em_right), 1);
        check_val("t4_first_not_left", int'(em_left), 0);
        clr();
        sample();
        run_count(91);
        check_val("t4_right_total", c_r, 80);
        check_val("t4_left_total", c_l, 0);
        check_val("t4_starve_cycles", c_st, 33);
        check_val("t4_forced_cnt", c_fr, 2);
        check_val("t4_overlap", c_both, 0);
        cyc();
        check_val("t4_third_left", int'(em_left), 1);
        check_val("t4_third_not_right", int'(em_right), 0);
        check_val("t4_starve_clear", int'(starve_flag), 0);
        req_left  = 1'b0;
        req_right = 1'b0;
        clr();
        run_count(40);
        check_val("t4_left_tail", c_l, 9);
        check_val("t4_no_right_after", c_r, 0);
        check_val("t4_settle", int'(busy), 0);

        // T5: left request arriving during COOL is serviced only after COOL ends.
        req_right = 1'b1;
        run_count(3);
        req_right = 1'b0;
        run_count(11);
        check_val("t5_in_cool_r", int'(em_right), 0);
        check_val("t5_in_cool_busy", int'(busy), 1);
        req_left = 1'b1;
        clr();
        sample();
        run_count(4);
        check_val("t5_cool_no_grant", c_l + c_r, 0);
        check_val("t5_cool_len", c_busy, 5);
        cyc();
        check_val("t5_idle_gap", int'(em_left), 0);
        cyc();
        check_val("t5_left_after_cool", int'(em_left), 1);
        req_left = 1'b0;
        run_count(30);
        check_val("t5_settle", int'(busy), 0);

        // T6: asynchronous reset in the 5th grant cycle, then fresh debounce.
        req_right = 1'b1;
        run_count(4);
        run_count(4);
        check_val("t6_granted", int'(em_right), 1);
        #2 reset = 1'b1;
        #1;
        check_val("t6_async_em", int'(em_right), 0);
        check_val("t6_async_busy", int'(busy), 0);
        cyc();
        check_val("t6_held_em", int'(em_right), 0);
        #2 reset = 1'b0;
        clr();
        run_count(3);
        check_val("t6_redebounce", c_r, 0);
        cyc();
        check_val("t6_regrant", int'(em_right), 1);
        req_right = 1'b0;
        run_count(30);
        check_val("t6_settle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
